// File: rtl/nibble_feeder.sv
// Nibble feeder: small FIFO that hands one nibble per 4-cycle frame to a divide-by-4 sync stage.
// Define NIBBLE_FEEDER_UNDERRUN_CNT_EN to add the saturating underrun_cnt event counter.
module nibble_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    fast_clk,
    input  logic                    rst,
    input  logic [3:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [3:0]              data,
    output logic                    data_upd,
    output logic [1:0]              phase,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    underrun,
    input  logic                    clr_underrun
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [7:0]              underrun_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [1:0]    phase_q, phase_d;
    logic [3:0]    mem_q [DEPTH];
    logic [3:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    data_q, data_d;
    logic          data_upd_q, data_upd_d;
    logic          underrun_q, underrun_d;

    logic slot, empty, full, push, pop, underrun_evt;

    // Emptiness is judged on registered state, so a push landing on the slot edge waits a frame.
    always_comb begin
        slot         = (phase_q == 2'd3);
        empty        = (level_q == '0);
        full         = (level_q == LW'(DEPTH));
        push         = in_valid && !full;
        pop          = slot && !empty;
        underrun_evt = slot && empty;
    end

    always_comb begin
        phase_d    = phase_q + 2'd1;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        data_d     = data_q;
        data_upd_d = pop;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        // A new empty-slot event outranks a concurrent clear.
        if (underrun_evt) begin
            underrun_d = 1'b1;
        end else if (clr_underrun) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= 4'h0;
            data_upd_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_q     <= data_d;
            data_upd_q <= data_upd_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage needs no reset: occupancy and pointers alone decide what is readable.
    always_ff @(posedge fast_clk) begin
        mem_q <= mem_d;
    end

`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
    logic [7:0] cnt_q, cnt_d, cnt_base;

    // Clear applies first, then the event increments, so clear+event yields 1.
    always_comb begin
        cnt_base = clr_underrun ? 8'd0 : cnt_q;
        cnt_d    = cnt_base;
        if (underrun_evt && (cnt_base != 8'hFF)) begin
            cnt_d = cnt_base + 8'd1;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign underrun_cnt = cnt_q;
`endif

    assign in_ready   = !full;
    assign data       = data_q;
    assign data_upd   = data_upd_q;
    assign phase      = phase_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_nibble_feeder.sv
// Directed bench for nibble_feeder: scoreboard of accepted nibbles checked against each data_upd.
// Also covers underrun_cnt when NIBBLE_FEEDER_UNDERRUN_CNT_EN is defined.
module tb_nibble_feeder;

    localparam int DEPTH = 4;

    logic                   fast_clk;
    logic                   rst;
    logic [3:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [3:0]             data;
    logic                   data_upd;
    logic [1:0]             phase;
    logic [$clog2(DEPTH):0] fifo_level;
    logic                   underrun;
    logic                   clr_underrun;
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
    logic [7:0]             underrun_cnt;
`endif

    nibble_feeder #(.DEPTH(DEPTH)) dut (
        .fast_clk     (fast_clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data         (data),
        .data_upd     (data_upd),
        .phase        (phase),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial begin
        fast_clk = 1'b0;
        forever #5 fast_clk = ~fast_clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  sb [$];
    logic [1:0]  exp_phase = 2'd0;
    int          exp_level = 0;
    logic [3:0]  exp_data = 4'h0;
    logic        exp_upd = 1'b0;
    logic        exp_underrun = 1'b0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [3:0]  prev_data;
    logic        acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: predict the edge from the current inputs, then sample 1 time unit after it.
    task automatic step();
        logic push, pop, ev;
        logic [7:0] base;
        push = !rst && in_valid && (exp_level != DEPTH);
        pop  = !rst && (exp_phase == 2'd3) && (exp_level != 0);
        ev   = !rst && (exp_phase == 2'd3) && (exp_level == 0);
        if (push) sb.push_back(in_data);
        @(posedge fast_clk);
        #1;
        if (rst) begin
            exp_phase    = 2'd0;
            exp_level    = 0;
            exp_data     = 4'h0;
            exp_upd      = 1'b0;
            exp_underrun = 1'b0;
            exp_cnt      = 8'd0;
            sb.delete();
        end else begin
            exp_phase = exp_phase + 2'd1;
            exp_level = exp_level + (push ? 1 : 0) - (pop ? 1 : 0);
            exp_upd   = pop;
            if (ev) exp_underrun = 1'b1;
            else if (clr_underrun) exp_underrun = 1'b0;
            base = clr_underrun ? 8'd0 : exp_cnt;
            exp_cnt = (ev && base != 8'hFF) ? base + 8'd1 : base;
            if (pop) exp_data = sb.pop_front();
        end
        check("phase", phase, exp_phase);
        check("fifo_level", fifo_level, exp_level);
        check("in_ready", in_ready, exp_level != DEPTH);
        check("data_upd", data_upd, exp_upd);
        check("data", data, exp_data);
        check("underrun", underrun, exp_underrun);
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, exp_cnt);
`endif
    endtask

    task automatic step_to(input logic [1:0] target);
        for (int i = 0; i < 4 && exp_phase != target; i++) step();
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 4'h0;
        clr_underrun = 1'b0;

        // Reset state
        step();
        rst = 1'b0;
        check("rst_phase", phase, 0);
        check("rst_data", data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", in_ready, 1);

        // Two idle frames: underrun each slot, data held at 0
        repeat (4) step();
        check("idle_underrun", underrun, 1);
        repeat (4) step();
        check("idle_data", data, 0);
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
        check("idle_cnt", underrun_cnt, 2);
`endif

        // Clear coinciding with an empty slot: set wins; clear alone clears
        step_to(2'd3);
        clr_underrun = 1'b1;
        step();
        check("clr_vs_set", underrun, 1);
        step();
        clr_underrun = 1'b0;
        check("clr_alone", underrun, 0);
`ifdef NIBBLE_FEEDER_UNDERRUN_CNT_EN
        check("clr_cnt", underrun_cnt, 0);
`endif

        // A, 5, C back-to-back from phase 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 4'hA; step();
        in_data = 4'h5; step();
        in_data = 4'hC; step();
        in_valid = 1'b0;
        step();
        check("frame1_A", data, 4'hA);
        check("frame1_upd", data_upd, 1);
        repeat (4) step();
        check("frame2_5", data, 4'h5);
        repeat (4) step();
        check("frame3_C", data, 4'hC);
        check("drained", fifo_level, 0);

        // Back-pressure: six offers with continuous valid
        for (int v = 1; v <= 6; v++) begin
            in_valid = 1'b1;
            in_data = 4'(v);
            acc = 1'b0;
            for (int t = 0; t < 16 && !acc; t++) begin
                acc = (exp_level != DEPTH);
                step();
            end
            check("accepted", acc, 1);
            if (v == 5) begin
                check("full_ready", in_ready, 0);
                check("full_level", fifo_level, DEPTH);
            end
        end
        in_valid = 1'b0;
        repeat (24) step();
        check("bp_drained", fifo_level, 0);
        check("bp_last", data, 4'h6);
        check("bp_sb_empty", sb.size(), 0);

        // Push into empty FIFO on the slot edge waits one frame
        step_to(2'd3);
        prev_data = exp_data;
        in_valid = 1'b1;
        in_data = 4'h7;
        step();
        in_valid = 1'b0;
        check("late_hold", data, prev_data);
        repeat (4) step();
        check("late_load", data, 4'h7);

        // Mid-frame reset flushes three queued entries and a push in the reset cycle
        step_to(2'd3);
        in_valid = 1'b1;
        in_data = 4'h9; step();
        in_data = 4'hB; step();
        in_data = 4'hD; step();
        check("pre_rst_level", fifo_level, 3);
        rst = 1'b1;
        in_data = 4'hE;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mid_rst_phase", phase, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_level", fifo_level, 0);
        repeat (12) step();
        check("flushed_data", data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_feeder.md
NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port fast_clk  in  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data  in  4  nibble offered by the producer.
REQ-005 The block SHALL have port in_valid  in  1  in_data valid this cycle.
REQ-006 The block SHALL have port in_ready  out  1  FIFO can accept; transfer when in_valid & in_ready.
REQ-007 The block SHALL have port data  out  4  registered nibble to the downstream sync stage, held for one 4-cycle frame.
REQ-008 The block SHALL have port data_upd  out  1  one-cycle pulse, high in the cycle data first shows a newly loaded value.
REQ-009 The block SHALL have port phase  out  2  free-running frame phase counter.
REQ-010 The block SHALL have port fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 The block SHALL have port underrun  out  1  sticky flag, frame slot found FIFO empty.
REQ-012 The block SHALL have port clr_underrun  in  1  clears underrun (and underrun_cnt when compiled in).

Function
REQ-013 phase SHALL increment by 1 every fast_clk cycle, wrapping 3 -> 0, matching the downstream divide-by-4 enable (enable at phase 3).
REQ-014 At each edge where phase==3 and FIFO non-empty, the head entry SHALL be popped into data; data_upd SHALL be high during the following cycle (phase 0).
REQ-015 data SHALL change only on the 3 -> 0 phase edge, so it is stable across phases 0..3 of every frame.
REQ-016 At a phase-3 edge with FIFO empty, data SHALL hold its previous value, data_upd SHALL stay low, underrun SHALL be set.
REQ-017 The FIFO SHALL be first-in-first-out with no loss or duplication; latency from accept to data is at least 1 cycle, no bypass path.
REQ-018 in_ready SHALL equal (fifo_level != DEPTH) computed from registered state only; a full FIFO refuses a push even in a pop cycle.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave fifo_level unchanged.
REQ-020 A push into an empty FIFO on a phase-3 edge SHALL NOT be loaded that frame; it loads at the next phase-3 edge.
REQ-021 Pointers SHALL wrap modulo DEPTH; fifo_level SHALL never exceed DEPTH nor go below 0.
REQ-022 If clr_underrun and a new underrun event occur in the same cycle, set SHALL win.

Reset
REQ-023 While rst is high at an edge: phase=0, data=4'h0, data_upd=0, fifo_level=0, in_ready=1 after the edge, underrun=0, pointers=0.
REQ-024 Reset mid-operation SHALL flush all FIFO contents; no entry accepted before reset shall appear on data afterwards.
REQ-025 Pushes presented in a reset cycle SHALL be discarded.

Configuration
REQ-026 Macro NIBBLE_FEEDER_UNDERRUN_CNT_EN SHALL, when defined, add port underrun_cnt  out  8, counting underrun events, saturating at 255, reset to 0, cleared by clr_underrun (increment wins over clear in the same cycle, result 1).
REQ-027 Without NIBBLE_FEEDER_UNDERRUN_CNT_EN the port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset, then push 4'hA,4'h5,4'hC back-to-back from phase 0 -> data=A in frame 1, 5 in frame 2, C in frame 3, data_upd pulses at each phase 0, fifo_level returns to 0.
REQ-029 DEPTH=4, push 5 nibbles with pop slots avoided -> in_ready drops after 4th accept, 5th held until next phase-3 pop, fifo_level never exceeds 4.
REQ-030 No pushes after reset for 2 frames -> data stays 0, underrun=1 after first phase-3 edge, underrun_cnt=2 (macro defined), no data_upd.
REQ-031 Push 4'h7 into empty FIFO exactly at phase 3 -> data unchanged next frame, data=7 one frame later.
REQ-032 Fill FIFO with 3 entries, assert rst for 1 cycle mid-frame -> phase=0, data=0, fifo_level=0, none of the 3 entries ever appears on data.
REQ-033 Hold clr_underrun high on a cycle with a simultaneous empty-slot event -> underrun remains 1; clr_underrun alone -> underrun=0, underrun_cnt=0.
